// File: rtl/count_mon_pkg.sv
// Shared types and constants for the counter event monitor.
package count_mon_pkg;

    typedef enum logic [1:0] {
        ZONE_MID  = 2'd0,
        ZONE_LOW  = 2'd1,
        ZONE_HIGH = 2'd2
    } zone_e;

    localparam int unsigned EVT_WRAP_UP  = 0;
    localparam int unsigned EVT_WRAP_DN  = 1;
    localparam int unsigned EVT_HI_ENTER = 2;
    localparam int unsigned EVT_LO_ENTER = 3;
    localparam int unsigned EVT_DIR_CHG  = 4;
    localparam int unsigned EVT_NUM      = 5;

    localparam int unsigned CNT_WIDTH = 8;

    typedef struct packed {
        logic [EVT_NUM-1:0]   flags;
        logic [CNT_WIDTH-1:0] cnt;
    } evt_rec_t;

endpackage

// File: rtl/cem_fifo.sv
// Synchronous FIFO for event records; the caller decides whether a push is legal.
module cem_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          pop_eff;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_eff = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/count_event_monitor.sv
// Watches an up/down counter for wraps, zone entries and direction changes; queues events.
// Optional CEM_WRAP_COUNT_EN adds a saturating wrap_cnt output.
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HYST       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   cnt_in,
    input  logic               dir_in,
    input  logic               mon_en,
    input  logic [WIDTH-1:0]   thr_hi,
    input  logic [WIDTH-1:0]   thr_lo,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [EVT_NUM-1:0] evt_flags,
    output logic [WIDTH-1:0]   evt_cnt,
    output logic [1:0]         zone,
    output logic               ovf_sticky,
    input  logic               clr_sticky
`ifdef CEM_WRAP_COUNT_EN
   ,output logic [15:0]        wrap_cnt
`endif
);

    localparam int unsigned      REC_W    = EVT_NUM + WIDTH;
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH:0]   HYST_EXT = (WIDTH + 1)'(HYST);

    logic [WIDTH-1:0]   cur_q, prev_q;
    logic               dir_q, pdir_q;
    logic               cap_valid_q;
    logic               prime_q, prime_d;
    zone_e              zone_q, zone_d, zone_calc;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     hi_diff, lo_sum;
    logic [WIDTH-1:0]   hi_exit, lo_exit;
    logic               in_hi, in_lo, active;
    logic [EVT_NUM-1:0] flags;
    logic               push, pop, drop, fifo_wr;
    logic               fifo_full, fifo_empty;
    logic [REC_W-1:0]   fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q       <= '0;
            prev_q      <= '0;
            dir_q       <= 1'b0;
            pdir_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            prime_q     <= 1'b1;
            zone_q      <= ZONE_MID;
            ovf_q       <= 1'b0;
        end else begin
            cur_q       <= cnt_in;
            prev_q      <= cur_q;
            dir_q       <= dir_in;
            pdir_q      <= dir_q;
            cap_valid_q <= 1'b1;
            prime_q     <= prime_d;
            zone_q      <= zone_d;
            ovf_q       <= ovf_d;
        end
    end

    // Exit thresholds saturate instead of wrapping.
    assign hi_diff = {1'b0, thr_hi} - HYST_EXT;
    assign lo_sum  = {1'b0, thr_lo} + HYST_EXT;
    assign hi_exit = hi_diff[WIDTH] ? '0 : hi_diff[WIDTH-1:0];
    assign lo_exit = lo_sum[WIDTH] ? CNT_MAX : lo_sum[WIDTH-1:0];

    assign in_hi  = (cur_q >= thr_hi);
    assign in_lo  = (cur_q <= thr_lo);
    assign active = cap_valid_q && mon_en;

    always_comb begin
        zone_calc = zone_q;
        if (in_hi) begin
            zone_calc = ZONE_HIGH;
        end else if (in_lo) begin
            zone_calc = ZONE_LOW;
        end else if (zone_q == ZONE_HIGH && cur_q < hi_exit) begin
            zone_calc = ZONE_MID;
        end else if (zone_q == ZONE_LOW && cur_q > lo_exit) begin
            zone_calc = ZONE_MID;
        end
    end

    always_comb begin
        flags               = '0;
        flags[EVT_WRAP_UP]  = (prev_q == CNT_MAX) && (cur_q == '0);
        flags[EVT_WRAP_DN]  = (prev_q == '0) && (cur_q == CNT_MAX);
        flags[EVT_HI_ENTER] = in_hi && (zone_q != ZONE_HIGH);
        flags[EVT_LO_ENTER] = !in_hi && in_lo && (zone_q != ZONE_LOW);
        flags[EVT_DIR_CHG]  = (dir_q != pdir_q);
    end

    // Prime stays armed until the first valid sample seen with monitoring on.
    always_comb begin
        zone_d  = active ? zone_calc : zone_q;
        prime_d = prime_q;
        if (!mon_en) begin
            prime_d = 1'b1;
        end else if (cap_valid_q) begin
            prime_d = 1'b0;
        end
    end

    assign push    = active && !prime_q && (|flags);
    assign pop     = evt_valid && evt_ready;
    assign drop    = push && fifo_full && !pop;
    assign fifo_wr = push && (!fifo_full || pop);

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_sticky) begin
            ovf_d = 1'b0;
        end
    end

    cem_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_wr),
        .pop   (pop),
        .din   ({flags, cur_q}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_flags  = fifo_empty ? '0 : fifo_dout[REC_W-1:WIDTH];
    assign evt_cnt    = fifo_empty ? '0 : fifo_dout[WIDTH-1:0];
    assign zone       = zone_q;
    assign ovf_sticky = ovf_q;

`ifdef CEM_WRAP_COUNT_EN
    logic [15:0] wrap_cnt_q, wrap_cnt_d;
    logic        wrap_hit;

    assign wrap_hit = fifo_wr && (flags[EVT_WRAP_UP] || flags[EVT_WRAP_DN]);

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_hit) begin
            if (wrap_cnt_q != 16'hFFFF) wrap_cnt_d = wrap_cnt_q + 16'd1;
        end else if (clr_sticky) begin
            wrap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wrap_cnt_q <= '0;
        else     wrap_cnt_q <= wrap_cnt_d;
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Randomized scoreboard bench for count_event_monitor against a behavioural event model.
module tb_count_event_monitor;

    localparam int DEPTH = 4;
    localparam int HYST  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cnt_in;
    logic       dir_in;
    logic       mon_en;
    logic [7:0] thr_hi, thr_lo;
    logic       evt_valid, evt_ready;
    logic [4:0] evt_flags;
    logic [7:0] evt_cnt;
    logic [1:0] zone;
    logic       ovf_sticky, clr_sticky;
`ifdef CEM_WRAP_COUNT_EN
    logic [15:0] wrap_cnt;
`endif

    count_event_monitor #(
        .WIDTH      (8),
        .FIFO_DEPTH (DEPTH),
        .HYST       (HYST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .dir_in     (dir_in),
        .mon_en     (mon_en),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_flags  (evt_flags),
        .evt_cnt    (evt_cnt),
        .zone       (zone),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
`ifdef CEM_WRAP_COUNT_EN
       ,.wrap_cnt   (wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample history, zone, prime, FIFO occupancy and expected records.
    logic [12:0] exp_q[$];
    int m_cur, m_prev, m_dir, m_pdir, m_ncap, m_zone, m_occ, m_wrap;
    bit m_prime, m_ovf;

    task automatic step(input int c, input bit d, input bit en, input bit rdy, input bit clr,
                        input bit r);
        bit         pop, acc, drop, hi, lo;
        logic [4:0] f;
        int         nz, hi_exit, lo_exit;
        cnt_in = 8'(c); dir_in = d; mon_en = en; evt_ready = rdy; clr_sticky = clr; rst = r;
        if (r) begin
            exp_q.delete();
            m_occ = 0; m_ncap = 0; m_zone = 0; m_prime = 1; m_ovf = 0; m_wrap = 0;
            m_cur = 0; m_prev = 0; m_dir = 0; m_pdir = 0;
        end else begin
            pop  = (m_occ > 0) && rdy;
            acc  = 0;
            drop = 0;
            f    = '0;
            if (m_ncap >= 1 && en) begin
                hi      = m_cur >= int'(thr_hi);
                lo      = m_cur <= int'(thr_lo);
                hi_exit = (int'(thr_hi) >= HYST) ? int'(thr_hi) - HYST : 0;
                lo_exit = (int'(thr_lo) + HYST > 255) ? 255 : int'(thr_lo) + HYST;
                nz = m_zone;
                if (hi) nz = 2;
                else if (lo) nz = 1;
                else if (m_zone == 2 && m_cur < hi_exit) nz = 0;
                else if (m_zone == 1 && m_cur > lo_exit) nz = 0;
                if (!m_prime) begin
                    f[0] = (m_prev == 255) && (m_cur == 0);
                    f[1] = (m_prev == 0) && (m_cur == 255);
                    f[2] = hi && (m_zone != 2);
                    f[3] = !hi && lo && (m_zone != 1);
                    f[4] = (m_dir != m_pdir);
                    if (f != 0) begin
                        if (m_occ == DEPTH && !pop) drop = 1;
                        else begin
                            acc = 1;
                            exp_q.push_back({f, 8'(m_cur)});
                        end
                    end
                end
                m_zone  = nz;
                m_prime = 0;
            end else if (!en) begin
                m_prime = 1;
            end
            m_occ = m_occ - int'(pop) + int'(acc);
            if (drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (acc && (f[0] || f[1])) m_wrap = (m_wrap == 65535) ? 65535 : m_wrap + 1;
            else if (clr) m_wrap = 0;
            m_prev = m_cur; m_pdir = m_dir; m_cur = c & 255; m_dir = int'(d);
            m_ncap++;
        end
        @(posedge clk);
        #1;
        check("evt_valid", int'(evt_valid), int'(m_occ > 0));
        check("zone", int'(zone), m_zone);
        check("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
`ifdef CEM_WRAP_COUNT_EN
        check("wrap_cnt", int'(wrap_cnt), m_wrap);
`endif
        if (r) begin
            check("rst_flags", int'(evt_flags), 0);
            check("rst_cnt", int'(evt_cnt), 0);
        end
    endtask

    // Monitor: pops expected records on each DUT handshake; checks head stability while stalled.
    logic [12:0] hold_rec;
    bit          hold_v = 0;
    always @(negedge clk) begin
        logic [12:0] e;
        if (!rst && evt_valid) begin
            if (hold_v) check("head_stable", int'({evt_flags, evt_cnt}), int'(hold_rec));
            if (evt_ready) begin
                hold_v = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_record", int'({evt_flags, evt_cnt}), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_flags", int'(evt_flags), int'(e[12:8]));
                    check("evt_cnt", int'(evt_cnt), int'(e[7:0]));
                end
            end else begin
                hold_v   = 1;
                hold_rec = {evt_flags, evt_cnt};
            end
        end else begin
            hold_v = 0;
        end
    end

    initial begin
        int  c;
        bit  d, en, rdy, clr, r;
        thr_hi = 8'd252; thr_lo = 8'd3;
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 1, 1, 0, 1);
        // Wrap up through high then low zone.
        for (int i = 250; i <= 255; i++) step(i, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 0);
        // Wrap down from low into high.
        thr_lo = 8'd1;
        step(0, 0, 1, 1, 0, 1);
        step(2, 0, 1, 1, 0, 0); step(1, 0, 1, 1, 0, 0); step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(255, 0, 1, 1, 0, 0);
        // Hysteresis on the high zone.
        thr_hi = 8'd100; thr_lo = 8'd3;
        step(0, 1, 1, 1, 0, 1);
        step(99, 1, 1, 1, 0, 0); step(100, 1, 1, 1, 0, 0); step(99, 1, 1, 1, 0, 0);
        step(98, 1, 1, 1, 0, 0); step(97, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(100, 1, 1, 1, 0, 0);
        // Overflow with a stalled consumer, then drain and clear.
        thr_hi = 8'd200; thr_lo = 8'd10;
        step(0, 1, 1, 1, 0, 1);
        step(50, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(50, i[0], 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(50, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(50, 0, 1, 1, 0, 0);
        step(50, 0, 1, 1, 1, 0);
        // Single direction change in the mid zone.
        step(0, 1, 1, 1, 0, 1);
        step(50, 1, 1, 1, 0, 0); step(50, 1, 1, 1, 0, 0);
        step(49, 0, 1, 1, 0, 0); step(48, 0, 1, 1, 0, 0); step(47, 0, 1, 1, 0, 0);
        step(47, 0, 1, 1, 0, 0);
        // Reset with records queued.
        step(0, 1, 1, 1, 0, 1);
        step(60, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(60, i[0], 1, 0, 0, 0);
        step(60, 0, 1, 0, 0, 1);
        step(60, 1, 1, 1, 0, 0); step(61, 0, 1, 1, 0, 0); step(62, 0, 1, 1, 0, 0);

        // Random walk with occasional jumps, stalls, clears, disables and resets.
        c = 128; d = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                thr_hi = 8'($urandom_range(0, 255));
                thr_lo = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 7) == 0) d = ~d;
            if ($urandom_range(0, 40) == 0) c = $urandom_range(0, 255);
            else c = (c + (d ? 1 : -1)) & 255;
            en  = ($urandom_range(0, 19) != 0);
            rdy = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 29) == 0);
            r   = ($urandom_range(0, 399) == 0);
            step(c, d, en, rdy, clr, r);
        end
        for (int i = 0; i < 8; i++) step(c, d, 0, 1, 0, 0);
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
